// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the channel index map (L, C, R, U), the channel count and the
// debounce FSM state type used by every channel.
package btn_pkg;

    localparam int NUM_BTN = 4;

    localparam int BTN_L = 0;
    localparam int BTN_C = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_CONFIRM_PRESS   = 2'd1,
        ST_HELD            = 2'd2,
        ST_CONFIRM_RELEASE = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability-counter debounce FSM, optional auto-repeat.
// Latency: raw change first sampled at edge k -> level/pulse registered after edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
//
// Ports:
//   i_clock   - system clock, rising edge
//   i_reset   - synchronous active-high reset
//   i_raw     - asynchronous button pin
//   o_level   - debounced level (1 = pressed)
//   o_press   - one-cycle pulse per accepted press (and per auto-repeat)
//   o_release - one-cycle pulse per accepted release
// Configuration macro: BTN_REPEAT_EN enables the hold counter and auto-repeat pulses.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
    end

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

`ifdef BTN_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] r_hold;
    // 0 while waiting for the first repeat, 1 once the periodic cadence has started.
    logic          r_rep_phase;
    logic          w_rep_due;

    assign w_rep_due = r_rep_phase ? (r_hold == HOLD_NEXT) : (r_hold == HOLD_FIRST);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= ST_RELEASED;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
`ifdef BTN_REPEAT_EN
            r_hold      <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                ST_RELEASED: begin
                    if (r_sync2) begin
                        r_state <= ST_CONFIRM_PRESS;
                        r_cnt   <= CNT_ONE;
                    end
                end

                ST_CONFIRM_PRESS: begin
                    if (!r_sync2) begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
`ifdef BTN_REPEAT_EN
                        r_hold      <= '0;
                        r_rep_phase <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_HELD: begin
                    if (!r_sync2) begin
                        // Hold counter is left untouched here: it stays frozen
                        // through the release confirmation and resumes on a bounce back.
                        r_state <= ST_CONFIRM_RELEASE;
                        r_cnt   <= CNT_ONE;
                    end else begin
`ifdef BTN_REPEAT_EN
                        if (w_rep_due) begin
                            r_press     <= 1'b1;
                            r_hold      <= '0;
                            r_rep_phase <= 1'b1;
                        end else begin
                            r_hold <= r_hold + HOLD_ONE;
                        end
`endif
                    end
                end

                ST_CONFIRM_RELEASE: begin
                    if (r_sync2) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_RELEASED;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
`ifdef BTN_REPEAT_EN
                        r_hold      <= '0;
                        r_rep_phase <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Four-channel button front end: sync + debounce each pin, emit level and press/release pulses.
// Latency: DEBOUNCE_CYCLES+1 edges from first sampling a stable change to the registered outputs.
// Backpressure: none; the game core must consume each single-cycle press pulse as it occurs.
//
// Ports:
//   clock       - system clock, rising edge
//   reset       - synchronous active-high reset
//   btn_raw     - raw button pins, bit 0=L, 1=C, 2=R, 3=U
//   btn_level   - debounced level per channel (1 = pressed)
//   btn_press   - one-cycle press pulse per channel (plus auto-repeat when enabled)
//   btn_release - one-cycle release pulse per channel
// Configuration macro: BTN_REPEAT_EN enables auto-repeat press pulses while a button is held.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clock   (clock),
            .i_reset   (reset),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic [3:0] raw,
                       input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
        vec_t v;
        v.rst = rst;
        v.raw = raw;
        v.lvl = lvl;
        v.prs = prs;
        v.rel = rel;
        vecs.push_back(v);
    endtask

    // One press/release episode on the channels in mask. Edge e is the e-th
    // clock edge of the episode; raw is high on edges [0, hi_len). acc and rls
    // are the hand-computed acceptance edges (-1 = never accepted). Reset is
    // asserted on edges [rst_lo, rst_hi). With auto-repeat, extra press pulses
    // land at acc+10, acc+13, acc+16 while the level is still high.
    task automatic chan_seq(input logic [3:0] mask, input int n, input int hi_len,
                            input int acc, input int rls, input int rst_lo, input int rst_hi);
        for (int e = 0; e < n; e++) begin
            logic on;
            logic rp;
            on = (acc >= 0) && (e >= acc) && (e < rls);
            rp = (acc >= 0) && ((e == acc) ||
                 (REP && on && (e == acc + 10 || e == acc + 13 || e == acc + 16)));
            add((e >= rst_lo) && (e < rst_hi),
                (e < hi_len) ? mask : 4'b0000,
                on ? mask : 4'b0000,
                rp ? mask : 4'b0000,
                (e == rls) ? mask : 4'b0000);
        end
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b exp=%b", name, idx, got, exp);
        end
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++) add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Clean press on L: press/level after edge 5, release 5 edges after drop
        chan_seq(4'b0001, 17, 8, 5, 13, -1, -1);

        // Bounce on C: 2-cycle highs never qualify
        for (int e = 0; e < 12; e++)
            add(1'b0, ((e < 2) || (e >= 4 && e < 6)) ? 4'b0010 : 4'b0000,
                4'b0000, 4'b0000, 4'b0000);
        // 3-cycle high: one short of acceptance
        chan_seq(4'b0010, 10, 3, -1, -1, -1, -1);
        // 4-cycle high: minimum accepted press
        chan_seq(4'b0010, 12, 4, 5, 9, -1, -1);

        // Long hold and release on R
        chan_seq(4'b0100, 28, 20, 5, 25, -1, -1);

        // All four at once
        chan_seq(4'b1111, 14, 6, 5, 11, -1, -1);

        // Reset during CONFIRM_PRESS on U: progress discarded, press 6 edges after reset falls
        chan_seq(4'b1000, 20, 11, 10, 16, 3, 5);

        // Reset on the edge the press pulse would fire on L
        chan_seq(4'b0001, 22, 12, 11, 17, 5, 6);

        // Long hold on L for auto-repeat, then release
        chan_seq(4'b0001, 32, 22, 5, 27, -1, -1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            btn_raw = vecs[i].raw;
            @(posedge clock);
            #1;
            chk("level",   i, btn_level,   vecs[i].lvl);
            chk("press",   i, btn_press,   vecs[i].prs);
            chk("release", i, btn_release, vecs[i].rel);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
